// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: latches the result at start, holds busy for a fixed latency, then commits to HI/LO.
// Stall to D is combinational: busy, or an E-stage mult/div start, while D holds an MDU instruction.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] divisor, abs_a, abs_b, quot_m, rem_m;
  logic [31:0] quot_u, rem_u, quot_s, rem_s;

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Divide-by-zero results are discarded, so a dummy divisor keeps the dividers defined.
  assign divisor = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign quot_u  = rs_val / divisor;
  assign rem_u   = rs_val % divisor;
  assign abs_a   = rs_val[31]  ? -rs_val  : rs_val;
  assign abs_b   = divisor[31] ? -divisor : divisor;
  assign quot_m  = abs_a / abs_b;
  assign rem_m   = abs_a % abs_b;
  assign quot_s  = (rs_val[31] ^ divisor[31]) ? -quot_m : quot_m;
  assign rem_s   = rs_val[31] ? -rem_m : rem_m;

  always_comb begin
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (count_q != '0) begin
      count_d = count_q - 1'b1;
      if (count_q == CW'(1)) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (start) begin
      case (op)
        OP_MULT: begin
          {pend_hi_d, pend_lo_d} = prod_s;
          count_d = CW'(MULT_CYCLES);
        end
        OP_MULTU: begin
          {pend_hi_d, pend_lo_d} = prod_u;
          count_d = CW'(MULT_CYCLES);
        end
        OP_DIV: begin
          pend_hi_d = (rt_val == 32'd0) ? hi_q : rem_s;
          pend_lo_d = (rt_val == 32'd0) ? lo_q : quot_s;
          count_d   = CW'(DIV_CYCLES);
        end
        OP_DIVU: begin
          pend_hi_d = (rt_val == 32'd0) ? hi_q : rem_u;
          pend_lo_d = (rt_val == 32'd0) ? lo_q : quot_u;
          count_d   = CW'(DIV_CYCLES);
        end
        OP_MTHI: hi_d = rs_val;
        OP_MTLO: lo_d = rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign busy  = (count_q != '0);
  assign stall = d_md_use & (busy | (start & ~op[2]));
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
